// File: rtl/vidac_list.sv
// vidac_list: command-list vector drawing engine on the shared 8-bit video memory port.
// Fetches opcodes and little-endian arguments from CMD_BASE onward, then plots one
// clipped pixel per cycle (LINE, RECT outline/filled, PIXEL, CLEAR) until END.
module vidac_list #(
   parameter int            AW       = 18,
   parameter int            SCR_W    = 320,
   parameter int            SCR_H    = 200,
   parameter logic [AW-1:0] FB_BASE  = 18'h00000,
   parameter logic [AW-1:0] CMD_BASE = 18'h20000
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          cmd,
   input  logic          abort,
   output logic [AW-1:0] a,
   input  logic [7:0]    i,
   output logic [7:0]    o,
   output logic          w,
   output logic          bsy,
   output logic          done,
   output logic          err
);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_OP, S_ARGS, S_SETUP, S_LINE, S_RECT, S_PIXEL, S_CLEAR
   } state_t;

   // 18-bit signed coordinates: 16-bit arguments plus headroom for deltas and 2*err
   typedef logic signed [17:0] coord_t;

   localparam logic [2:0] OP_LINE  = 3'd1;
   localparam logic [2:0] OP_RECT  = 3'd2;
   localparam logic [2:0] OP_FILL  = 3'd3;
   localparam logic [2:0] OP_PIXEL = 3'd4;

   localparam coord_t        ZERO     = '0;
   localparam coord_t        ONE      = coord_t'(1);
   localparam coord_t        W_LIM    = coord_t'(SCR_W);
   localparam coord_t        H_LIM    = coord_t'(SCR_H);
   localparam logic [AW-1:0] CLR_LAST = FB_BASE + AW'(SCR_W * SCR_H - 1);

   // Linear framebuffer address of (px,py); only meaningful when on screen
   function automatic logic [AW-1:0] pix_addr(input coord_t px, input coord_t py);
      logic signed [35:0] lin;
      lin = 36'(py) * 36'(SCR_W) + 36'(px);
      return FB_BASE + lin[AW-1:0];
   endfunction

   function automatic logic on_screen(input coord_t px, input coord_t py);
      return (px >= ZERO) && (px < W_LIM) && (py >= ZERO) && (py < H_LIM);
   endfunction

   state_t        state, state_nx;
   logic [AW-1:0] a_nx, ptr, ptr_nx;
   logic [7:0]    o_nx;
   logic          w_nx, bsy_nx, done_nx, err_nx;
   logic [2:0]    opc, opc_nx;
   logic [3:0]    arg_cnt, arg_cnt_nx, arg_last, arg_last_nx;
   logic          args_we;
   logic [7:0]    args [0:8];

   // Walk position, end/right/bottom corner, left/top corner and line error terms
   coord_t x, y, xe, ye, xl, yt, dx, dy, lerr;
   coord_t x_nx, y_nx, xe_nx, ye_nx, xl_nx, yt_nx, dx_nx, dy_nx, lerr_nx;
   logic   sx_neg, sx_neg_nx;

   // Decoded arguments and derived geometry
   coord_t ax1, ay1, ax2, ay2;
   coord_t lx1, ly1, lx2, ly2, ldx;
   coord_t rxl, rxr, ryt, ryb;
   coord_t e2, lnx, lny, lnerr, rnx, rny;
   logic   full_row;

   assign ax1 = coord_t'($signed({args[1], args[0]}));
   assign ay1 = coord_t'($signed({args[3], args[2]}));
   assign ax2 = coord_t'($signed({args[5], args[4]}));
   assign ay2 = coord_t'($signed({args[7], args[6]}));

   // Geometry: endpoint swap, rectangle normalisation and next-pixel candidates
   always_comb begin
      lx1 = (ay1 > ay2) ? ax2 : ax1;
      ly1 = (ay1 > ay2) ? ay2 : ay1;
      lx2 = (ay1 > ay2) ? ax1 : ax2;
      ly2 = (ay1 > ay2) ? ay1 : ay2;
      ldx = lx2 - lx1;
      rxl = (ax1 < ax2) ? ax1 : ax2;
      rxr = (ax1 < ax2) ? ax2 : ax1;
      ryt = (ay1 < ay2) ? ay1 : ay2;
      ryb = (ay1 < ay2) ? ay2 : ay1;

      // Bresenham step; y only ever moves down after the swap
      e2    = lerr <<< 1;
      lnx   = x;
      lny   = y;
      lnerr = lerr;
      if (e2 >= dy) begin
         lnerr = lnerr + dy;
         lnx   = sx_neg ? x - ONE : x + ONE;
      end
      if (e2 <= dx) begin
         lnerr = lnerr + dx;
         lny   = y + ONE;
      end

      // Raster step; outline inner rows jump from the left edge to the right edge
      full_row = (opc == OP_FILL) || (y == yt) || (y == ye);
      rnx = xl;
      rny = y + ONE;
      if (full_row && (x != xe)) begin
         rnx = x + ONE;
         rny = y;
      end else if (!full_row && (x == xl) && (xl != xe)) begin
         rnx = xe;
         rny = y;
      end
   end

   // Next-state and next-output logic for the command walker
   always_comb begin
      // NOTE: every target gets a default before the case so no path can infer a latch.
      state_nx    = state;
      a_nx        = a;
      o_nx        = o;
      w_nx        = 1'b0;
      bsy_nx      = bsy;
      done_nx     = 1'b0;
      err_nx      = err;
      opc_nx      = opc;
      arg_cnt_nx  = arg_cnt;
      arg_last_nx = arg_last;
      ptr_nx      = ptr;
      args_we     = 1'b0;
      x_nx        = x;
      y_nx        = y;
      xe_nx       = xe;
      ye_nx       = ye;
      xl_nx       = xl;
      yt_nx       = yt;
      dx_nx       = dx;
      dy_nx       = dy;
      lerr_nx     = lerr;
      sx_neg_nx   = sx_neg;

      case (state)
         S_IDLE: begin
            if (cmd) begin
               state_nx = S_FETCH;
               bsy_nx   = 1'b1;
               err_nx   = 1'b0;
               a_nx     = CMD_BASE;
            end
         end

         // Opcode address is on a; it returns on i next cycle
         S_FETCH: begin
            a_nx     = a + AW'(1);
            state_nx = S_OP;
         end

         S_OP: begin
            a_nx       = a + AW'(1);
            arg_cnt_nx = '0;
            opc_nx     = i[2:0];
            case (i)
               8'h00: begin
                  state_nx = S_IDLE;
                  bsy_nx   = 1'b0;
                  done_nx  = 1'b1;
               end
               8'h01, 8'h02, 8'h03: begin
                  arg_last_nx = 4'd8;
                  state_nx    = S_ARGS;
               end
               8'h04: begin
                  arg_last_nx = 4'd4;
                  state_nx    = S_ARGS;
               end
               8'h05: begin
                  arg_last_nx = 4'd0;
                  state_nx    = S_ARGS;
               end
               default: begin
                  state_nx = S_IDLE;
                  bsy_nx   = 1'b0;
                  done_nx  = 1'b1;
                  err_nx   = 1'b1;
               end
            endcase
         end

         // On the last argument byte, a already holds the next opcode address
         S_ARGS: begin
            args_we    = 1'b1;
            a_nx       = a + AW'(1);
            arg_cnt_nx = arg_cnt + 4'd1;
            if (arg_cnt == arg_last) begin
               ptr_nx   = a;
               state_nx = S_SETUP;
            end
         end

         S_SETUP: begin
            case (opc)
               OP_LINE: begin
                  x_nx      = lx1;
                  y_nx      = ly1;
                  xe_nx     = lx2;
                  ye_nx     = ly2;
                  sx_neg_nx = (ldx < ZERO);
                  dx_nx     = (ldx < ZERO) ? -ldx : ldx;
                  dy_nx     = ly1 - ly2;
                  lerr_nx   = dx_nx + dy_nx;
                  o_nx      = args[8];
                  if (ly1 >= H_LIM) begin
                     state_nx = S_FETCH;
                     a_nx     = ptr;
                  end else begin
                     state_nx = S_LINE;
                     a_nx     = pix_addr(lx1, ly1);
                     w_nx     = on_screen(lx1, ly1);
                  end
               end
               OP_RECT, OP_FILL: begin
                  x_nx  = rxl;
                  y_nx  = ryt;
                  xl_nx = rxl;
                  yt_nx = ryt;
                  xe_nx = rxr;
                  ye_nx = ryb;
                  o_nx  = args[8];
                  if (ryt >= H_LIM) begin
                     state_nx = S_FETCH;
                     a_nx     = ptr;
                  end else begin
                     state_nx = S_RECT;
                     a_nx     = pix_addr(rxl, ryt);
                     w_nx     = on_screen(rxl, ryt);
                  end
               end
               OP_PIXEL: begin
                  x_nx     = ax1;
                  y_nx     = ay1;
                  o_nx     = args[4];
                  state_nx = S_PIXEL;
                  a_nx     = pix_addr(ax1, ay1);
                  w_nx     = on_screen(ax1, ay1);
               end
               default: begin
                  o_nx     = args[0];
                  state_nx = S_CLEAR;
                  a_nx     = FB_BASE;
                  w_nx     = 1'b1;
               end
            endcase
         end

         // a/o/w currently show (x,y); queue up the following pixel or finish
         S_LINE: begin
            if ((x == xe) && (y == ye)) begin
               state_nx = S_FETCH;
               a_nx     = ptr;
            end else if (lny >= H_LIM) begin
               state_nx = S_FETCH;
               a_nx     = ptr;
            end else begin
               x_nx    = lnx;
               y_nx    = lny;
               lerr_nx = lnerr;
               a_nx    = pix_addr(lnx, lny);
               w_nx    = on_screen(lnx, lny);
            end
         end

         S_RECT: begin
            if ((x == xe) && (y == ye)) begin
               state_nx = S_FETCH;
               a_nx     = ptr;
            end else if (rny >= H_LIM) begin
               state_nx = S_FETCH;
               a_nx     = ptr;
            end else begin
               x_nx = rnx;
               y_nx = rny;
               a_nx = pix_addr(rnx, rny);
               w_nx = on_screen(rnx, rny);
            end
         end

         S_PIXEL: begin
            state_nx = S_FETCH;
            a_nx     = ptr;
         end

         S_CLEAR: begin
            if (a == CLR_LAST) begin
               state_nx = S_FETCH;
               a_nx     = ptr;
            end else begin
               a_nx = a + AW'(1);
               w_nx = 1'b1;
            end
         end

         default: begin
            state_nx = S_IDLE;
            bsy_nx   = 1'b0;
         end
      endcase

      // Abort overrides everything while a list is running; err keeps its value
      if (bsy && abort) begin
         state_nx = S_IDLE;
         bsy_nx   = 1'b0;
         w_nx     = 1'b0;
         done_nx  = 1'b0;
         err_nx   = err;
      end
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      // NOTE: flops use <= so every register samples pre-edge values; combinational blocks use =.
      if (!reset_n) begin
         state    <= S_IDLE;
         a        <= '0;
         o        <= '0;
         w        <= 1'b0;
         bsy      <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         opc      <= '0;
         arg_cnt  <= '0;
         arg_last <= '0;
         ptr      <= '0;
         x        <= '0;
         y        <= '0;
         xe       <= '0;
         ye       <= '0;
         xl       <= '0;
         yt       <= '0;
         dx       <= '0;
         dy       <= '0;
         lerr     <= '0;
         sx_neg   <= 1'b0;
      end else begin
         state    <= state_nx;
         a        <= a_nx;
         o        <= o_nx;
         w        <= w_nx;
         bsy      <= bsy_nx;
         done     <= done_nx;
         err      <= err_nx;
         opc      <= opc_nx;
         arg_cnt  <= arg_cnt_nx;
         arg_last <= arg_last_nx;
         ptr      <= ptr_nx;
         x        <= x_nx;
         y        <= y_nx;
         xe       <= xe_nx;
         ye       <= ye_nx;
         xl       <= xl_nx;
         yt       <= yt_nx;
         dx       <= dx_nx;
         dy       <= dy_nx;
         lerr     <= lerr_nx;
         sx_neg   <= sx_neg_nx;
      end
   end

   // Argument byte capture, one byte per ARGS cycle
   always_ff @(posedge clock) begin
      // NOTE: the argument bytes are not reset; each one is written in ARGS before SETUP reads it.
      if (args_we) begin
         args[arg_cnt] <= i;
      end
   end

endmodule

// File: tb/tb_vidac_list.sv
// Directed bench for vidac_list: behavioural memory (1-cycle read latency), write log,
// and hand-computed expectations for each command list.
module tb_vidac_list;

   logic        clock = 1'b0;
   logic        reset_n, cmd, abort;
   logic [17:0] a;
   logic [7:0]  i, o;
   logic        w, bsy, done, err;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   vidac_list dut (
      .clock   (clock),
      .reset_n (reset_n),
      .cmd     (cmd),
      .abort   (abort),
      .a       (a),
      .i       (i),
      .o       (o),
      .w       (w),
      .bsy     (bsy),
      .done    (done),
      .err     (err)
   );

   // Framebuffer below 0x20000, command list from 0x20000
   logic [7:0] fb   [0:131071];
   logic [7:0] prog [0:255];

   always @(posedge clock) begin
      i <= a[17] ? prog[a[7:0]] : fb[a[16:0]];
      if (w === 1'b1 && !a[17]) fb[a[16:0]] <= o;
   end

   // Write log and pulse counters, sampled away from the active edge
   logic [17:0] wa [$];
   logic [7:0]  wd [$];
   int done_cnt = 0, bsy_cyc = 0, bad_w = 0;

   always @(negedge clock) begin
      if (w === 1'b1) begin
         wa.push_back(a);
         wd.push_back(o);
         if (bsy !== 1'b1) bad_w = bad_w + 1;
      end
      if (done === 1'b1) done_cnt = done_cnt + 1;
      if (bsy === 1'b1) bsy_cyc = bsy_cyc + 1;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   int pp;
   task automatic emit8(input logic [7:0] b);
      prog[pp] = b;
      pp++;
   endtask

   task automatic emit16(input int v);
      emit8(v[7:0]);
      emit8(v[15:8]);
   endtask

   function automatic logic [31:0] wa_at(input int k);
      return (k < wa.size()) ? 32'(wa[k]) : 32'hxxxx_xxxx;
   endfunction

   function automatic logic [31:0] wd_at(input int k);
      return (k < wd.size()) ? 32'(wd[k]) : 32'hxxxx_xxxx;
   endfunction

   task automatic clear_log();
      @(posedge clock);
      #1;
      wa.delete();
      wd.delete();
      done_cnt = 0;
      bsy_cyc  = 0;
   endtask

   task automatic start_list();
      @(negedge clock);
      cmd = 1'b1;
      @(negedge clock);
      cmd = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k = 0;
      while (bsy === 1'b1 && k < budget) begin
         @(negedge clock);
         k++;
      end
      check(tag, 32'(bsy), 32'd0);
      @(posedge clock);
      #1;
   endtask

   int exp_line [8]  = '{1610, 1929, 1928, 2247, 2246, 2565, 2564, 2883};
   int exp_fill [4]  = '{63678, 63679, 63998, 63999};
   int exp_rect [10] = '{642, 643, 644, 645, 962, 965, 1282, 1283, 1284, 1285};

   initial begin
      reset_n = 1'b0;
      cmd     = 1'b0;
      abort   = 1'b0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (10) @(negedge clock);
      check("rst_bsy", 32'(bsy), 32'd0);
      check("rst_w", 32'(w), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_a", 32'(a), 32'd0);
      check("rst_o", 32'(o), 32'd0);

      // Empty list: done pulse, two busy cycles, nothing written
      clear_log();
      pp = 0;
      emit8(8'h00);
      start_list();
      wait_idle("end_timeout", 20);
      check("end_done", 32'(done_cnt), 32'd1);
      check("end_bsy_cycles", 32'(bsy_cyc), 32'd2);
      check("end_writes", 32'(wa.size()), 32'd0);

      // LINE given bottom-first (3,9)-(10,5): swapped to start at (10,5)
      clear_log();
      pp = 0;
      emit8(8'h01);
      emit16(3); emit16(9); emit16(10); emit16(5);
      emit8(8'h2A);
      emit8(8'h00);
      start_list();
      wait_idle("line_timeout", 100);
      check("line_writes", 32'(wa.size()), 32'd8);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("line_a%0d", k), wa_at(k), 32'(exp_line[k]));
         check($sformatf("line_o%0d", k), wd_at(k), 32'h2A);
      end
      check("line_done", 32'(done_cnt), 32'd1);
      check("line_err", 32'(err), 32'd0);

      // Filled RECT straddling the bottom-right corner
      clear_log();
      pp = 0;
      emit8(8'h03);
      emit16(318); emit16(198); emit16(322); emit16(201);
      emit8(8'h07);
      emit8(8'h00);
      start_list();
      wait_idle("fill_timeout", 100);
      check("fill_writes", 32'(wa.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("fill_a%0d", k), wa_at(k), 32'(exp_fill[k]));
      end
      check("fill_o", wd_at(3), 32'h07);
      check("fill_done", 32'(done_cnt), 32'd1);

      // Outline RECT, then an off-screen PIXEL, then END
      clear_log();
      pp = 0;
      emit8(8'h02);
      emit16(2); emit16(2); emit16(5); emit16(4);
      emit8(8'h33);
      emit8(8'h04);
      emit16(-1); emit16(0);
      emit8(8'h44);
      emit8(8'h00);
      start_list();
      wait_idle("rect_timeout", 100);
      check("rect_writes", 32'(wa.size()), 32'd10);
      for (int k = 0; k < 10; k++) begin
         check($sformatf("rect_a%0d", k), wa_at(k), 32'(exp_rect[k]));
      end
      check("rect_o", wd_at(9), 32'h33);
      check("rect_done", 32'(done_cnt), 32'd1);

      // Valid PIXEL, then undefined opcode 0x09
      clear_log();
      pp = 0;
      emit8(8'h04);
      emit16(0); emit16(0);
      emit8(8'h01);
      emit8(8'h09);
      start_list();
      wait_idle("bad_timeout", 50);
      check("bad_writes", 32'(wa.size()), 32'd1);
      check("bad_a0", wa_at(0), 32'd0);
      check("bad_o0", wd_at(0), 32'h01);
      check("bad_err", 32'(err), 32'd1);
      check("bad_done", 32'(done_cnt), 32'd1);

      // CLEAR aborted after the 100th write; err from the previous list clears on start
      clear_log();
      pp = 0;
      emit8(8'h05);
      emit8(8'hFF);
      emit8(8'h00);
      start_list();
      check("start_err_clear", 32'(err), 32'd0);
      begin
         int n = 0;
         int k = 0;
         while (n < 100 && k < 2000) begin
            @(negedge clock);
            if (w === 1'b1) n++;
            k++;
         end
         check("clear_reach100", 32'(n), 32'd100);
      end
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      check("abort_bsy", 32'(bsy), 32'd0);
      check("abort_w", 32'(w), 32'd0);
      repeat (5) @(negedge clock);
      @(posedge clock);
      #1;
      check("abort_no_done", 32'(done_cnt), 32'd0);
      check("abort_writes", 32'(wa.size()), 32'd100);
      check("abort_first_a", wa_at(0), 32'd0);
      check("abort_last_a", wa_at(99), 32'd99);
      check("abort_last_o", wd_at(99), 32'hFF);
      check("abort_fb99", 32'(fb[99]), 32'hFF);

      check("w_while_idle", 32'(bad_w), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
